pattern_seq: RTL and testbench

Parametrised multi-channel step-pattern sequencer. An internal prescaler divides iCLK into step ticks. On each tick the block advances through a loaded pattern of up to MAX_LEN steps and drives CH parallel output bits per step. It supports repeat and one-shot modes, a start/stop handshake and glitch-free pattern reload while running. It sits between the board clock and LED/buzzer/indicator pins and replaces fixed hard-coded blink sequencers.

---
 rtl/pattern_seq_pkg.sv | 25 ++
 rtl/pattern_seq_step_tick.sv | 30 +++
 rtl/pattern_seq.sv | 149 ++++++++++++++
 tb/tb_pattern_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// rtl/pattern_seq_pkg.sv - shared state encoding, mode constants and width helpers for pattern_seq
package pattern_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seqState_t;

   localparam logic MODE_REPEAT  = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   // Length must encode 0..MAX_LEN inclusive; step only 0..MAX_LEN-1.
   function automatic int lenWidth(input int maxLen);
      return $clog2(maxLen + 1);
   endfunction

   function automatic int stepWidth(input int maxLen);
      return (maxLen > 1) ? $clog2(maxLen) : 1;
   endfunction

   function automatic int divWidth(input int clkDiv);
      return (clkDiv > 1) ? $clog2(clkDiv) : 1;
   endfunction

endpackage

// File: rtl/pattern_seq_step_tick.sv
// rtl/pattern_seq_step_tick.sv - prescaler producing one step tick every CLK_DIV clocks
module step_tick
   import pattern_seq_pkg::*;
#(
   parameter int CLK_DIV = 2500000
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic iCLR,
   output logic oTICK
);

   localparam int CW = divWidth(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt <= '0;
      end else if (iCLR || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign oTICK = (cnt == LAST) && !iCLR;

endmodule

// File: rtl/pattern_seq.sv
// rtl/pattern_seq.sv - multi-channel step-pattern sequencer with shadowed reload
module pattern_seq
   import pattern_seq_pkg::*;
#(
   parameter int CLK_DIV = 2500000,
   parameter int MAX_LEN = 16,
   parameter int CH      = 1
) (
   input  logic                           iCLK,
   input  logic                           iRST_N,
   input  logic                           iLOAD,
   input  logic [MAX_LEN*CH-1:0]          iPATTERN,
   input  logic [lenWidth(MAX_LEN)-1:0]   iLEN,
   input  logic                           iMODE,
   input  logic                           iSTART,
   input  logic                           iSTOP,
   output logic [CH-1:0]                  oSIG,
   output logic [stepWidth(MAX_LEN)-1:0]  oSTEP,
   output logic                           oBUSY,
   output logic                           oDONE
);

   localparam int LW = lenWidth(MAX_LEN);
   localparam int SW = stepWidth(MAX_LEN);
   localparam int PW = MAX_LEN * CH;
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

   seqState_t     state, stateNxt;
   logic [SW-1:0] step, stepNxt;
   logic [PW-1:0] actPat, actPatNxt, shdPat, shdPatNxt, pendPat;
   logic [LW-1:0] actLen, actLenNxt, shdLen, shdLenNxt, pendLen, loadLen;
   logic          pending, pendingNxt, mode, modeNxt, doneNxt;
   logic          tick, clr, rewind, pendAny;
   logic [CH-1:0] sigNxt;

   step_tick #(.CLK_DIV(CLK_DIV)) uTick (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iCLR   (clr),
      .oTICK  (tick)
   );

   assign loadLen = (iLEN > LEN_MAX) ? LEN_MAX : iLEN;
   // A load in the same cycle as a rewind takes effect at that rewind.
   assign pendAny = pending | iLOAD;
   assign pendPat = iLOAD ? iPATTERN : shdPat;
   assign pendLen = iLOAD ? loadLen : shdLen;

   always_comb begin
      stateNxt   = state;
      stepNxt    = step;
      actPatNxt  = actPat;
      actLenNxt  = actLen;
      shdPatNxt  = shdPat;
      shdLenNxt  = shdLen;
      pendingNxt = pending;
      modeNxt    = mode;
      doneNxt    = 1'b0;
      clr        = 1'b0;
      rewind     = 1'b0;
      sigNxt     = '0;

      if (state == IDLE) begin
         clr = 1'b1;
         if (iLOAD) begin
            actPatNxt = iPATTERN;
            actLenNxt = loadLen;
         end
         if (iSTART && !iSTOP && actLenNxt != '0) begin
            stateNxt = RUN;
            stepNxt  = '0;
            modeNxt  = iMODE;
         end
      end else begin
         if (iLOAD) begin
            shdPatNxt  = iPATTERN;
            shdLenNxt  = loadLen;
            pendingNxt = 1'b1;
         end
         if (iSTOP) begin
            stateNxt = IDLE;
            stepNxt  = '0;
            clr      = 1'b1;
            rewind   = 1'b1;
         end else if (iSTART) begin
            stepNxt = '0;
            modeNxt = iMODE;
            clr     = 1'b1;
            rewind  = 1'b1;
         end else if (tick) begin
            if (LW'(step) != actLen - LW'(1)) begin
               stepNxt = step + SW'(1);
            end else if (mode == MODE_REPEAT) begin
               stepNxt = '0;
               rewind  = 1'b1;
            end else begin
               stateNxt = IDLE;
               stepNxt  = '0;
               doneNxt  = 1'b1;
               rewind   = 1'b1;
            end
         end
         if (rewind && pendAny) begin
            actPatNxt  = pendPat;
            actLenNxt  = pendLen;
            pendingNxt = 1'b0;
         end
         // A shadow of length 0 cannot be played, so it parks the sequencer.
         if (rewind && actLenNxt == '0) begin
            stateNxt = IDLE;
         end
      end

      if (stateNxt == RUN) begin
         sigNxt = actPatNxt[int'(stepNxt)*CH +: CH];
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state   <= IDLE;
         step    <= '0;
         actPat  <= '0;
         actLen  <= '0;
         shdPat  <= '0;
         shdLen  <= '0;
         pending <= 1'b0;
         mode    <= MODE_REPEAT;
         oSIG    <= '0;
         oBUSY   <= 1'b0;
         oDONE   <= 1'b0;
      end else begin
         state   <= stateNxt;
         step    <= stepNxt;
         actPat  <= actPatNxt;
         actLen  <= actLenNxt;
         shdPat  <= shdPatNxt;
         shdLen  <= shdLenNxt;
         pending <= pendingNxt;
         mode    <= modeNxt;
         oSIG    <= sigNxt;
         oBUSY   <= (stateNxt == RUN);
         oDONE   <= doneNxt;
      end
   end

   assign oSTEP = step;

endmodule

// File: tb/tb_pattern_seq.sv
// tb/tb_pattern_seq.sv - randomized self-checking bench for pattern_seq against a per-offset model
module tb_pattern_seq;

   localparam int CD = 4;
   localparam int ML = 12;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        load = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0;
   logic [11:0] pat = '0;
   logic [3:0]  len = '0;
   logic        sig, busy, done;
   logic [3:0]  step;

   logic        load2 = 1'b0, mode2 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
   logic [23:0] pat2 = '0;
   logic [3:0]  len2 = '0;
   logic [1:0]  sig2;
   logic        busy2, done2;
   logic [3:0]  step2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pattern_seq #(.CLK_DIV(CD), .MAX_LEN(ML), .CH(1)) dut (
      .iCLK(clk), .iRST_N(rstN), .iLOAD(load), .iPATTERN(pat), .iLEN(len),
      .iMODE(mode), .iSTART(start), .iSTOP(stop),
      .oSIG(sig), .oSTEP(step), .oBUSY(busy), .oDONE(done)
   );

   pattern_seq #(.CLK_DIV(CD), .MAX_LEN(ML), .CH(2)) dut2 (
      .iCLK(clk), .iRST_N(rstN), .iLOAD(load2), .iPATTERN(pat2), .iLEN(len2),
      .iMODE(mode2), .iSTART(start2), .iSTOP(stop2),
      .oSIG(sig2), .oSTEP(step2), .oBUSY(busy2), .oDONE(done2)
   );

   // Expected {busy,done,step,sig} at d cycles after the start was accepted.
   function automatic logic [6:0] expRun(input logic [11:0] p, input int l, input logic m, input int d);
      int k;
      if (m && d >= l * CD) return {1'b0, (d == l * CD), 4'd0, 1'b0};
      k = (d / CD) % l;
      return {1'b1, 1'b0, 4'(k), p[k]};
   endfunction

   task automatic pulseLoad(input logic [11:0] p, input logic [3:0] l);
      @(negedge clk); load = 1'b1; pat = p; len = l;
      @(negedge clk); load = 1'b0;
   endtask

   task automatic pulseStart(input logic m);
      @(negedge clk); start = 1'b1; mode = m;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic pulseStop();
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, step, sig, busy2, done2, step2, sig2} !== 15'd0) begin
         bad++;
         $display("FAIL reset_held got=%h exp=0", {busy, done, step, sig, busy2, done2, step2, sig2});
      end
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, step, sig} !== 7'd0) begin
         bad++;
         $display("FAIL reset_released got=%h exp=0", {busy, done, step, sig});
      end
   endtask

   task automatic test_repeat();
      pulseLoad(12'h133, 4'd12);
      pulseStart(1'b0);
      for (int d = 0; d < 3 * ML * CD; d++) begin
         total++;
         if ({busy, done, step, sig} !== expRun(12'h133, 12, 1'b0, d)) begin
            bad++;
            $display("FAIL repeat d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(12'h133, 12, 1'b0, d));
         end
         @(negedge clk);
      end
      pulseStop();
   endtask

   task automatic test_oneshot();
      int busyCnt = 0;
      int doneCnt = 0;
      pulseStart(1'b1);
      for (int d = 0; d < ML * CD + 12; d++) begin
         busyCnt += int'(busy);
         doneCnt += int'(done);
         total++;
         if ({busy, done, step, sig} !== expRun(12'h133, 12, 1'b1, d)) begin
            bad++;
            $display("FAIL oneshot d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(12'h133, 12, 1'b1, d));
         end
         @(negedge clk);
      end
      total++;
      if (busyCnt !== 48) begin
         bad++;
         $display("FAIL oneshot_busy_cycles got=%0d exp=48", busyCnt);
      end
      total++;
      if (doneCnt !== 1) begin
         bad++;
         $display("FAIL oneshot_done_pulses got=%0d exp=1", doneCnt);
      end
   endtask

   task automatic test_reload_running();
      logic [6:0] e;
      pulseStart(1'b0);
      for (int d = 0; d < 2 * ML * CD; d++) begin
         e = (d < ML * CD) ? expRun(12'h133, 12, 1'b0, d) : expRun(12'hFFF, 3, 1'b0, d - ML * CD);
         total++;
         if ({busy, done, step, sig} !== e) begin
            bad++;
            $display("FAIL reload d=%0d got=%h exp=%h", d, {busy, done, step, sig}, e);
         end
         if (d == 5 * CD) begin load = 1'b1; pat = 12'hFFF; len = 4'd3; end
         if (d == 5 * CD + 1) load = 1'b0;
         @(negedge clk);
      end
      pulseStop();
   endtask

   task automatic test_stop();
      pulseLoad(12'h133, 4'd12);
      pulseStart(1'b0);
      for (int d = 0; d <= 7 * CD; d++) begin
         total++;
         if ({busy, done, step, sig} !== expRun(12'h133, 12, 1'b0, d)) begin
            bad++;
            $display("FAIL stop_prerun d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(12'h133, 12, 1'b0, d));
         end
         if (d == 7 * CD) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      for (int d = 0; d < 8; d++) begin
         total++;
         if ({busy, done, step, sig} !== 7'd0) begin
            bad++;
            $display("FAIL stop_idle d=%0d got=%h exp=0", d, {busy, done, step, sig});
         end
         @(negedge clk);
      end
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int d = 0; d < 6; d++) begin
         total++;
         if ({busy, done, step, sig} !== 7'd0) begin
            bad++;
            $display("FAIL start_stop_same got=%h exp=0", {busy, done, step, sig});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_len_limits();
      pulseLoad(12'hABC, 4'd0);
      pulseStart(1'b0);
      for (int d = 0; d < 10; d++) begin
         total++;
         if ({busy, done, step, sig} !== 7'd0) begin
            bad++;
            $display("FAIL len_zero_start got=%h exp=0", {busy, done, step, sig});
         end
         @(negedge clk);
      end
      pulseLoad(12'h133, 4'd15);
      pulseStart(1'b1);
      for (int d = 0; d < ML * CD + 6; d++) begin
         total++;
         if ({busy, done, step, sig} !== expRun(12'h133, 12, 1'b1, d)) begin
            bad++;
            $display("FAIL len_clamp d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(12'h133, 12, 1'b1, d));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_restart_at_terminal();
      logic [11:0] p;
      p = 12'($urandom);
      pulseLoad(p, 4'd3);
      pulseStart(1'b1);
      for (int d = 0; d < 3 * CD; d++) begin
         total++;
         if ({busy, done, step, sig} !== expRun(p, 3, 1'b1, d)) begin
            bad++;
            $display("FAIL restart_first d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(p, 3, 1'b1, d));
         end
         if (d == 3 * CD - 1) start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      for (int d = 0; d < 3 * CD + 3; d++) begin
         total++;
         if ({busy, done, step, sig} !== expRun(p, 3, 1'b1, d)) begin
            bad++;
            $display("FAIL restart_second d=%0d got=%h exp=%h", d, {busy, done, step, sig}, expRun(p, 3, 1'b1, d));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random_load_start();
      logic [11:0] p;
      logic [3:0]  lIn;
      logic        m;
      int          l, cycles;
      for (int it = 0; it < 8; it++) begin
         p = 12'($urandom);
         lIn = 4'($urandom_range(1, 15));
         m = 1'($urandom_range(0, 1));
         l = (int'(lIn) > ML) ? ML : int'(lIn);
         cycles = m ? l * CD + 4 : 2 * l * CD + 3;
         @(negedge clk);
         load = 1'b1; pat = p; len = lIn; start = 1'b1; mode = m;
         @(negedge clk);
         load = 1'b0; start = 1'b0;
         for (int d = 0; d < cycles; d++) begin
            total++;
            if ({busy, done, step, sig} !== expRun(p, l, m, d)) begin
               bad++;
               $display("FAIL random it=%0d d=%0d got=%h exp=%h", it, d, {busy, done, step, sig}, expRun(p, l, m, d));
            end
            @(negedge clk);
         end
         pulseStop();
      end
   endtask

   task automatic test_two_channel_and_reset();
      logic [1:0] e;
      for (int k = 0; k < ML; k++) begin
         e = (k % 2 == 1) ? 2'b10 : 2'b01;
         pat2[k*2 +: 2] = e;
      end
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk); load2 = 1'b1; len2 = 4'd12;
         @(negedge clk); load2 = 1'b0; start2 = 1'b1; mode2 = 1'b0;
         @(negedge clk); start2 = 1'b0;
         for (int d = 0; d < 4 * CD; d++) begin
            e = ((d / CD) % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if ({busy2, done2, step2, sig2} !== {1'b1, 1'b0, 4'(d / CD), e}) begin
               bad++;
               $display("FAIL ch2 pass=%0d d=%0d got=%h exp=%h", pass, d, {busy2, done2, step2, sig2}, {1'b1, 1'b0, 4'(d / CD), e});
            end
            if (pass == 0 && d == CD + 2) begin
               #2 rstN = 1'b0;
               #1;
               total++;
               if ({busy2, done2, step2, sig2, busy, done, step, sig} !== 15'd0) begin
                  bad++;
                  $display("FAIL async_reset got=%h exp=0", {busy2, done2, step2, sig2, busy, done, step, sig});
               end
               @(negedge clk);
               rstN = 1'b1;
               break;
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_repeat();
      test_oneshot();
      test_reload_running();
      test_stop();
      test_len_limits();
      test_restart_at_terminal();
      test_random_load_start();
      test_two_channel_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
